// File: rtl/latch_write_if.sv
// Handshake and latch-bank signals between clocked lab logic and the gated D latch write controller.
// The master side is the requester and the latch bank, and the slave side is the controller.
interface latch_write_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] lat_d;
    logic             lat_g;
    logic [WIDTH-1:0] lat_q;
    logic             done;
    logic             err;
    logic             busy;
    logic [7:0]       err_cnt;

    modport master (
        output in_valid, in_data, lat_q,
        input  in_ready, lat_d, lat_g, done, err, busy, err_cnt
    );

    modport slave (
        input  in_valid, in_data, lat_q,
        output in_ready, lat_d, lat_g, done, err, busy, err_cnt
    );
endinterface

// File: rtl/latch_write_ctrl.sv
// Write sequencer for an asynchronous gated D latch bank: setup, gate pulse, hold, then a
// synchronized Q readback compare. All latch drives come straight from flops, so they cannot glitch.
module latch_write_ctrl #(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    latch_write_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, CHECK} state_t;

    // CHECK always dwells 2 cycles, so the counter must reach at least 1.
    localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_B   = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
    localparam int MAX_CYC = (MAX_B > 2) ? MAX_B : 2;
    localparam int CNT_W   = $clog2(MAX_CYC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             lat_g_q, lat_g_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic             mismatch;

    assign mismatch = (sync2_q != exp_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d_d   = lat_d_q;
        exp_d     = exp_q;
        lat_g_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        sync1_d   = bus.lat_q;
        sync2_d   = sync1_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SETUP;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    lat_d_d = bus.in_data;
                    exp_d   = bus.in_data;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = GATE;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    lat_g_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    lat_g_d = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                // The synchronizer has been refilled since the gate closed; Q is now trustworthy.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = mismatch;
                    if (mismatch && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_d_q   <= '0;
            exp_q     <= '0;
            lat_g_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_d_q   <= lat_d_d;
            exp_q     <= exp_d;
            lat_g_q   <= lat_g_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.lat_d    = lat_d_q;
    assign bus.lat_g    = lat_g_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule
